// File: rtl/uart_rx_deserializer.sv
// UART receive front end: 16x oversampled start detection, 5-8 data bits LSB first,
// optional parity, stop check and break detection; one FIFO write per completed frame.
module uart_rx_deserializer #(
    parameter int SYNC_STAGES   = 2,
    parameter int MAJORITY_VOTE = 1
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_baud_tick16,
    input  logic       i_rx_pin,
    input  logic [1:0] i_data_bits,
    input  logic       i_parity_enable,
    input  logic       i_parity_odd,
    output logic       o_fifo_we,
    output logic [7:0] o_data_out,
    output logic       o_frame_error,
    output logic       o_parity_error,
    output logic       o_break_detected,
    output logic       o_rx_busy
);

    // state     | meaning
    // IDLE      | waiting for a low line on a tick
    // START     | validating the start bit at mid-bit
    // DATA      | shifting in data bits LSB first
    // PARITY    | capturing the parity bit
    // STOP      | checking stop, writing the frame at mid-bit
    // BREAKWAIT | line held low after a break; wait for it to go high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAKWAIT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0] r_tick_cnt;
    logic [1:0] r_samp;
    logic [2:0] r_bit_idx;
    logic [2:0] r_last_idx;
    logic       r_par_en;
    logic       r_par_odd;
    logic       r_par_bit;
    logic [7:0] r_data;
    logic       r_fifo_we;
    logic [7:0] r_data_out;
    logic       r_frame_error;
    logic       r_parity_error;
    logic       r_break_detected;

    logic w_rx_s;
    logic w_mid;
    logic w_wrap;
    logic w_vote;
    logic w_bit;
    logic w_start_det;
    logic w_brk;
    logic w_par_err;

    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_mid       = i_baud_tick16 && (r_tick_cnt == 4'd9);
    assign w_wrap      = i_baud_tick16 && (r_tick_cnt == 4'd15);
    assign w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx_s) | (r_samp[1] & w_rx_s);
    assign w_bit       = (MAJORITY_VOTE != 0) ? w_vote : r_samp[1];
    assign w_start_det = (r_state == S_IDLE) && i_baud_tick16 && !w_rx_s;
    assign w_brk       = (r_data == 8'd0) && !(r_par_en && r_par_bit) && !w_bit;
    assign w_par_err   = r_par_en && ((^r_data ^ r_par_bit) != r_par_odd);

    // Reset loads 1s so that leaving reset never looks like a falling start edge.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_pin};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start_det) w_state_next = S_START;
            S_START: begin
                if (w_mid && w_bit)  w_state_next = S_IDLE;
                else if (w_wrap)     w_state_next = S_DATA;
            end
            S_DATA:      if (w_wrap && (r_bit_idx == r_last_idx))
                             w_state_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY:    if (w_wrap) w_state_next = S_STOP;
            S_STOP:      if (w_mid) w_state_next = w_brk ? S_BREAKWAIT : S_IDLE;
            S_BREAKWAIT: if (i_baud_tick16 && w_rx_s) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tick_cnt       <= 4'd0;
            r_samp           <= 2'b11;
            r_bit_idx        <= 3'd0;
            r_last_idx       <= 3'd7;
            r_par_en         <= 1'b0;
            r_par_odd        <= 1'b0;
            r_par_bit        <= 1'b0;
            r_data           <= 8'd0;
            r_fifo_we        <= 1'b0;
            r_data_out       <= 8'd0;
            r_frame_error    <= 1'b0;
            r_parity_error   <= 1'b0;
            r_break_detected <= 1'b0;
        end else begin
            r_fifo_we <= 1'b0;
            if (i_baud_tick16) begin
                r_tick_cnt <= (r_state == S_IDLE) ? 4'd0 : r_tick_cnt + 4'd1;
                if (r_tick_cnt == 4'd7) r_samp[0] <= w_rx_s;
                if (r_tick_cnt == 4'd8) r_samp[1] <= w_rx_s;
            end
            if (w_start_det) begin
                r_last_idx <= {1'b1, i_data_bits};
                r_par_en   <= i_parity_enable;
                r_par_odd  <= i_parity_odd;
                r_par_bit  <= 1'b0;
                r_data     <= 8'd0;
                r_bit_idx  <= 3'd0;
            end
            if (r_state == S_DATA && w_mid)   r_data[r_bit_idx] <= w_bit;
            if (r_state == S_DATA && w_wrap)  r_bit_idx <= r_bit_idx + 3'd1;
            if (r_state == S_PARITY && w_mid) r_par_bit <= w_bit;
            if (r_state == S_STOP && w_mid) begin
                r_fifo_we        <= 1'b1;
                r_data_out       <= r_data;
                r_frame_error    <= !w_bit;
                r_parity_error   <= w_par_err;
                r_break_detected <= w_brk;
            end
        end
    end

    assign o_fifo_we        = r_fifo_we;
    assign o_data_out       = r_data_out;
    assign o_frame_error    = r_frame_error;
    assign o_parity_error   = r_parity_error;
    assign o_break_detected = r_break_detected;
    assign o_rx_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus randomized frames, each checked
// against expected fields computed from the transmitted bit sequence.
module tb_uart_rx_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       rx;
    logic [1:0] data_bits;
    logic       par_en;
    logic       par_odd;
    logic       fifo_we;
    logic [7:0] data_out;
    logic       frame_error;
    logic       parity_error;
    logic       break_detected;
    logic       rx_busy;

    uart_rx_deserializer #(.SYNC_STAGES(2), .MAJORITY_VOTE(1)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_baud_tick16   (tick),
        .i_rx_pin        (rx),
        .i_data_bits     (data_bits),
        .i_parity_enable (par_en),
        .i_parity_odd    (par_odd),
        .o_fifo_we       (fifo_we),
        .o_data_out      (data_out),
        .o_frame_error   (frame_error),
        .o_parity_error  (parity_error),
        .o_break_detected(break_detected),
        .o_rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
        int         stop_idx;
    } frame_t;

    frame_t sb[$];
    frame_t mon_e;
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_writes = 0;
    int     n_exp    = 0;
    int     tb_gap   = 2;
    int     tb_bit   = 99;
    int     tb_pos   = 0;
    logic   prev_we  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int k = 1; k < tb_gap; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic v, input int idx, input int nticks);
        rx = v;
        tb_bit = idx;
        for (int t = 1; t <= nticks; t++) begin
            tb_pos = t;
            do_tick();
        end
    endtask

    task automatic send_idle(input int nbits);
        for (int b = 0; b < nbits; b++) send_bit(1'b1, 99, 16);
    endtask

    // Expected fields come from the bit sequence actually put on the line.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic pen,
                              input logic podd, input logic pflip, input logic stop_v,
                              input int idle_bits);
        int         nb;
        logic [7:0] dm;
        logic       pbit;
        logic       bits[$];
        frame_t     e;
        nb   = int'(db) + 5;
        dm   = d & 8'((1 << nb) - 1);
        pbit = (^dm) ^ podd ^ pflip;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stop_v);
        e.data     = dm;
        e.fe       = !stop_v;
        e.pe       = pen && pflip;
        e.brk      = (dm == 8'd0) && (!pen || !pbit) && !stop_v;
        e.stop_idx = bits.size() - 1;
        sb.push_back(e);
        n_exp++;
        data_bits = db;
        par_en    = pen;
        par_odd   = podd;
        for (int b = 0; b < bits.size(); b++) begin
            send_bit(bits[b], b, 16);
            if (b == 0) begin
                data_bits = 2'($urandom);
                par_en    = 1'($urandom);
                par_odd   = 1'($urandom);
            end
        end
        send_idle(idle_bits);
    endtask

    always @(negedge clk) begin
        if (fifo_we) begin
            chk("we_width", {31'd0, prev_we}, 32'd0);
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                n_writes++;
                chk("data_out", {24'd0, data_out}, {24'd0, mon_e.data});
                chk("frame_error", {31'd0, frame_error}, {31'd0, mon_e.fe});
                chk("parity_error", {31'd0, parity_error}, {31'd0, mon_e.pe});
                chk("break_detected", {31'd0, break_detected}, {31'd0, mon_e.brk});
                chk("we_bit", tb_bit, mon_e.stop_idx);
                chk("we_pos", {31'd0, (tb_pos >= 12) && (tb_pos <= 14)}, 32'd1);
            end
        end
        prev_we = fifo_we;
    end

    initial begin
        rst = 1'b1; tick = 1'b0; rx = 1'b1;
        data_bits = 2'b11; par_en = 1'b0; par_odd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, fifo_we}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_flags", {29'd0, frame_error, parity_error, break_detected}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        send_idle(2);

        tb_gap = 2;
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        tb_gap = 1;
        send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        send_frame(8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        tb_gap = 3;
        send_frame(8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        send_frame(8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        // line break: low for three 8N1 frame times, a single write expected
        tb_gap = 2;
        data_bits = 2'b11; par_en = 1'b0; par_odd = 1'b0;
        sb.push_back('{data: 8'h00, fe: 1'b1, pe: 1'b0, brk: 1'b1, stop_idx: 9});
        n_exp++;
        for (int b = 0; b < 30; b++) send_bit(1'b0, b, 16);
        send_idle(2);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // 4-tick glitch on an idle line
        send_bit(1'b0, 98, 4);
        rx = 1'b1;
        for (int t = 5; t <= 16; t++) begin
            tb_pos = t;
            do_tick();
            if (t == 9)  chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
            if (t == 14) chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
        end
        send_idle(1);

        // reset in the middle of data bit 3
        data_bits = 2'b11; par_en = 1'b0;
        send_bit(1'b0, 0, 16);
        send_bit(1'b1, 1, 16);
        send_bit(1'b0, 2, 16);
        send_bit(1'b1, 3, 16);
        send_bit(1'b0, 4, 8);
        chk("mid_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rx  = 1'b1;
        chk("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_mid_data", {24'd0, data_out}, 32'd0);
        send_idle(2);
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            tb_gap = $urandom_range(1, 3);
            d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            send_frame(d, 2'($urandom), 1'($urandom), 1'($urandom),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0,
                       $urandom_range(1, 3));
        end

        send_idle(3);
        chk("sb_empty", sb.size(), 32'd0);
        chk("write_count", n_writes, n_exp);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
